// File: rtl/t_bank_seq.sv
// Sequencer that drives a bank of T flip-flops as a loadable up/down register.
// LOAD/INC/DEC commands arrive over valid/ready. Each cycle it emits the toggle mask t_vec.
module t_bank_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {OpNop = 2'b00, OpLoad = 2'b01, OpInc = 2'b10, OpDec = 2'b11} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             wrap_seen_q, wrap_seen_d;

  logic [WIDTH-1:0] inc_mask, dec_mask;
  op_e              cmd_op_e;

  assign cmd_op_e = op_e'(cmd_op);

  // Ripple-carry toggle masks: bit i toggles when all lower bits are 1 (INC) or 0 (DEC).
  always_comb begin
    logic inc_c;
    logic dec_c;
    inc_mask = '0;
    dec_mask = '0;
    inc_c    = 1'b1;
    dec_c    = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      inc_mask[i] = inc_c;
      dec_mask[i] = dec_c;
      inc_c       = inc_c & q_q[i];
      dec_c       = dec_c & ~q_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    q_d         = q_q;
    data_d      = data_q;
    rem_d       = rem_q;
    wrap_seen_d = wrap_seen_q;
    t_vec       = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = cmd_op_e;
          data_d      = cmd_data;
          wrap_seen_d = 1'b0;
          unique case (cmd_op_e)
            OpLoad: begin
              rem_d   = CNT_W'(1);
              state_d = StRun;
            end
            OpInc, OpDec: begin
              rem_d   = cmd_count;
              state_d = (cmd_count == '0) ? StDone : StRun;
            end
            default: begin
              rem_d   = '0;
              state_d = StDone;
            end
          endcase
        end
      end

      StRun: begin
        if (abort) begin
          // Partial result is kept; only the pending toggles are suppressed.
          state_d = StDone;
        end else begin
          unique case (op_q)
            OpLoad: t_vec = q_q ^ data_q;
            OpInc: begin
              t_vec = inc_mask;
              if (&q_q) wrap_seen_d = 1'b1;
            end
            OpDec: begin
              t_vec = dec_mask;
              if (~|q_q) wrap_seen_d = 1'b1;
            end
            default: t_vec = '0;
          endcase
          q_d   = q_q ^ t_vec;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= OpNop;
      q_q         <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      wrap_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      q_q         <= q_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      wrap_seen_q <= wrap_seen_d;
    end
  end

  assign q         = q_q;
  assign qbar      = ~q_q;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign wrap      = (state_q == StDone) && wrap_seen_q;

endmodule

// File: tb/tb_t_bank_seq.sv
// Bench for t_bank_seq: directed scenarios plus random commands checked against an
// arithmetic model of the register value (q+1, q-1, load).
module tb_t_bank_seq;

  localparam logic [1:0] NOP = 2'b00, LOAD = 2'b01, INC = 2'b10, DEC = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_count;
  logic       abort;
  logic [7:0] t_vec, q, qbar;
  logic       busy, done, wrap;

  int n_pass = 0;
  int n_total = 0;

  // Traces captured while a command executes.
  logic [7:0] tv_tr[$];
  logic [7:0] q_tr[$];
  int         ndone, nrdy0;
  logic       wrap_o, timed_out;

  // Model state and expectations.
  logic [7:0] mq;
  logic [7:0] exp_tv[$];
  logic [7:0] exp_q[$];
  logic       exp_wrap;

  t_bank_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .abort(abort), .t_vec(t_vec), .q(q),
    .qbar(qbar), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Expected per-step toggle masks and values from plain arithmetic on the register value.
  task automatic model_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] cnt,
                           input int ab);
    int n;
    logic [7:0] cur, nxt;
    exp_tv.delete();
    exp_q.delete();
    exp_wrap = 1'b0;
    n = (op == LOAD) ? 1 : (op == NOP) ? 0 : int'(cnt);
    cur = mq;
    for (int i = 0; i < n; i++) begin
      if (i == ab) begin
        exp_tv.push_back(8'h00);
        exp_q.push_back(cur);
        break;
      end
      if (op == LOAD) nxt = d;
      else if (op == INC) begin
        nxt = cur + 8'd1;
        if (cur == 8'hFF) exp_wrap = 1'b1;
      end else begin
        nxt = cur - 8'd1;
        if (cur == 8'h00) exp_wrap = 1'b1;
      end
      exp_tv.push_back(cur ^ nxt);
      exp_q.push_back(nxt);
      cur = nxt;
    end
    mq = cur;
  endtask

  // Issue one command from IDLE and record traces until the cycle after done.
  // Called and returns at #1 after a rising edge.
  task automatic exec_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] cnt,
                          input int ab);
    int   steps;
    logic was_busy, was_done;
    tv_tr.delete();
    q_tr.delete();
    ndone = 0; nrdy0 = 0; wrap_o = 1'b0; timed_out = 1'b1; steps = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      abort = busy && (steps == ab);
      #1;
      if (busy) begin
        tv_tr.push_back(t_vec);
        steps++;
      end
      if (done) begin
        ndone++;
        wrap_o = wrap;
      end
      if (!cmd_ready) nrdy0++;
      was_busy = busy;
      was_done = done;
      @(posedge clk); #1;
      abort = 1'b0;
      if (was_busy) q_tr.push_back(q);
      if (was_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = '0; cmd_count = '0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (q !== 8'h00) $display("FAIL reset_q got %h want 00", q); else n_pass++;
    n_total++; if (qbar !== 8'hFF) $display("FAIL reset_qbar got %h want FF", qbar); else n_pass++;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else n_pass++;
    n_total++; if ({busy, done, wrap} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, wrap}); else n_pass++;
    n_total++; if (t_vec !== 8'h00) $display("FAIL reset_tvec got %h want 00", t_vec); else n_pass++;
    rst = 1'b1;
    mq = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    model_cmd(LOAD, 8'hA5, 8'd0, -1);
    exec_cmd(LOAD, 8'hA5, 8'd0, -1);
    n_total++; if (timed_out !== 1'b0) $display("FAIL load_timeout got %b want 0", timed_out); else n_pass++;
    n_total++; if (tv_tr.size() != 1) $display("FAIL load_steps got %0d want 1", tv_tr.size()); else n_pass++;
    n_total++; if (tv_tr.size() > 0 && tv_tr[0] !== 8'hA5) $display("FAIL load_tvec got %h want A5", tv_tr[0]); else n_pass++;
    n_total++; if (q !== 8'hA5) $display("FAIL load_q got %h want A5", q); else n_pass++;
    n_total++; if (qbar !== 8'h5A) $display("FAIL load_qbar got %h want 5A", qbar); else n_pass++;
    n_total++; if (ndone != 1) $display("FAIL load_done_count got %0d want 1", ndone); else n_pass++;
    n_total++; if (nrdy0 != 2) $display("FAIL load_notready_cycles got %0d want 2", nrdy0); else n_pass++;
    #1;
    n_total++; if ({cmd_ready, done} !== 2'b10) $display("FAIL load_idle got %b want 10", {cmd_ready, done}); else n_pass++;
  endtask

  task automatic test_inc_wrap();
    logic [7:0] wq[3] = '{8'hFF, 8'h00, 8'h01};
    logic [7:0] wt[3] = '{8'h01, 8'hFF, 8'h01};
    model_cmd(LOAD, 8'hFE, 8'd0, -1);
    exec_cmd(LOAD, 8'hFE, 8'd0, -1);
    model_cmd(INC, 8'h00, 8'd3, -1);
    exec_cmd(INC, 8'h00, 8'd3, -1);
    n_total++; if (q_tr.size() != 3) $display("FAIL inc_steps got %0d want 3", q_tr.size()); else n_pass++;
    for (int i = 0; i < 3 && i < q_tr.size(); i++) begin
      n_total++; if (q_tr[i] !== wq[i]) $display("FAIL inc_q[%0d] got %h want %h", i, q_tr[i], wq[i]); else n_pass++;
      n_total++; if (tv_tr[i] !== wt[i]) $display("FAIL inc_tvec[%0d] got %h want %h", i, tv_tr[i], wt[i]); else n_pass++;
    end
    n_total++; if (ndone != 1 || wrap_o !== 1'b1) $display("FAIL inc_done_wrap got %0d/%b want 1/1", ndone, wrap_o); else n_pass++;
  endtask

  task automatic test_dec_wrap();
    model_cmd(LOAD, 8'h01, 8'd0, -1);
    exec_cmd(LOAD, 8'h01, 8'd0, -1);
    model_cmd(DEC, 8'h00, 8'd2, -1);
    exec_cmd(DEC, 8'h00, 8'd2, -1);
    n_total++; if (q_tr.size() != 2) $display("FAIL dec_steps got %0d want 2", q_tr.size()); else n_pass++;
    n_total++; if (q_tr.size() > 1 && (q_tr[0] !== 8'h00 || q_tr[1] !== 8'hFF))
      $display("FAIL dec_q got %h,%h want 00,FF", q_tr[0], q_tr[1]); else n_pass++;
    n_total++; if (ndone != 1 || wrap_o !== 1'b1) $display("FAIL dec_done_wrap got %0d/%b want 1/1", ndone, wrap_o); else n_pass++;
  endtask

  task automatic test_count0_nop();
    logic [7:0] q0;
    q0 = q;
    cmd_valid = 1'b1; cmd_op = INC; cmd_count = 8'd0; cmd_data = 8'h77;
    #1;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL c0_ready got %b want 1", cmd_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({done, wrap, cmd_ready} !== 3'b100) $display("FAIL c0_done got %b want 100", {done, wrap, cmd_ready}); else n_pass++;
    n_total++; if (t_vec !== 8'h00) $display("FAIL c0_tvec got %h want 00", t_vec); else n_pass++;
    cmd_op = NOP;
    @(posedge clk); #1;
    n_total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL nop_idle got %b want 01", {done, cmd_ready}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({done, wrap, t_vec} !== {2'b10, 8'h00}) $display("FAIL nop_done got %b/%h want 10/00", {done, wrap}, t_vec); else n_pass++;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({done, cmd_ready} !== 2'b01) $display("FAIL nop_after got %b want 01", {done, cmd_ready}); else n_pass++;
    n_total++; if (q !== q0) $display("FAIL c0_nop_q got %h want %h", q, q0); else n_pass++;
  endtask

  task automatic test_abort();
    model_cmd(LOAD, 8'h00, 8'd0, -1);
    exec_cmd(LOAD, 8'h00, 8'd0, -1);
    model_cmd(INC, 8'h00, 8'd10, 3);
    exec_cmd(INC, 8'h00, 8'd10, 3);
    n_total++; if (tv_tr.size() != 4) $display("FAIL abort_steps got %0d want 4", tv_tr.size()); else n_pass++;
    n_total++; if (tv_tr.size() == 4 && tv_tr[3] !== 8'h00) $display("FAIL abort_tvec got %h want 00", tv_tr[3]); else n_pass++;
    n_total++; if (q !== 8'h03) $display("FAIL abort_q got %h want 03", q); else n_pass++;
    n_total++; if (ndone != 1 || cmd_ready !== 1'b1) $display("FAIL abort_done got %0d/%b want 1/1", ndone, cmd_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_dec();
    int spurious;
    model_cmd(LOAD, 8'h10, 8'd0, -1);
    exec_cmd(LOAD, 8'h10, 8'd0, -1);
    cmd_valid = 1'b1; cmd_op = DEC; cmd_count = 8'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_total++; if (q !== 8'h00 || qbar !== 8'hFF) $display("FAIL rstmid_q got %h/%h want 00/FF", q, qbar); else n_pass++;
    n_total++; if ({busy, done, cmd_ready} !== 3'b001) $display("FAIL rstmid_flags got %b want 001", {busy, done, cmd_ready}); else n_pass++;
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) spurious++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (done) spurious++;
    n_total++; if (spurious != 0) $display("FAIL rstmid_done got %0d want 0", spurious); else n_pass++;
    mq = 8'h00;
    model_cmd(LOAD, 8'h3C, 8'd0, -1);
    exec_cmd(LOAD, 8'h3C, 8'd0, -1);
    n_total++; if (q !== 8'h3C || ndone != 1) $display("FAIL rstmid_load got %h/%0d want 3C/1", q, ndone); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] d, cnt;
    int ab;
    for (int k = 0; k < 40; k++) begin
      op  = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      cnt = 8'($urandom_range(0, 12));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      model_cmd(op, d, cnt, ab);
      exec_cmd(op, d, cnt, ab);
      n_total++; if (timed_out !== 1'b0 || ndone != 1) $display("FAIL rnd%0d_done got %0d/%b want 1/0", k, ndone, timed_out); else n_pass++;
      n_total++; if (tv_tr.size() != exp_tv.size()) $display("FAIL rnd%0d_steps got %0d want %0d", k, tv_tr.size(), exp_tv.size()); else n_pass++;
      for (int i = 0; i < exp_tv.size() && i < tv_tr.size() && i < q_tr.size(); i++) begin
        n_total++; if (tv_tr[i] !== exp_tv[i] || q_tr[i] !== exp_q[i])
          $display("FAIL rnd%0d_step%0d got %h/%h want %h/%h", k, i, tv_tr[i], q_tr[i], exp_tv[i], exp_q[i]); else n_pass++;
      end
      n_total++; if (wrap_o !== exp_wrap) $display("FAIL rnd%0d_wrap got %b want %b", k, wrap_o, exp_wrap); else n_pass++;
      n_total++; if (q !== mq || qbar !== ~mq) $display("FAIL rnd%0d_q got %h want %h", k, q, mq); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inc_wrap();
    test_dec_wrap();
    test_count0_nop();
    test_abort();
    test_reset_mid_dec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
